xx_mm_multi_addr_decoder: RTL and testbench
===========================================

// Module: xx_mm_multi_addr_decoder
// PURPOSE
// - Parametrised MMIO address decoder between the PCIe BAR master and NUM_SLV CSR slave blocks.
// - Upper SEL_W address bits select a slave; lower bits form the slave-local offset.
// - Tracks one outstanding read and times out unresponsive slaves.
// - Unmapped reads return a signature word; drops and timeouts are counted for debug.
// PARAMETERS
// ADDR_W      14    MMIO word-address width
// DATA_W      64    data width
// SEL_W       4     upper address bits used as slave index
// NUM_SLV     4     number of slaves, 1..2**SEL_W; index >= NUM_SLV is unmapped
// RD_TIMEOUT  255   cycles to wait for slave RD_DATA_V before forcing an error completion
// PORTS
// clk             in   1                clock
// rst_n           in   1                asynchronous, active-low reset
// iMM_WR_EN       in   1                master write strobe, single cycle
// iMM_RD_EN       in   1                master read strobe, single cycle
// iMM_ADDR        in   ADDR_W           master word address
// iMM_WR_DATA     in   DATA_W           master write data
// oMM_RD_DATA     out  DATA_W           read completion data
// oMM_RD_DATA_V   out  1                read completion valid, single cycle
// oMM_RD_BUSY     out  1                high while a read is outstanding
// CSR_ADDR        out  ADDR_W-SEL_W     slave-local offset, broadcast to all slaves
// CSR_WR_DATA     out  DATA_W           write data, broadcast to all slaves
// CSR_WR_EN       out  NUM_SLV          one-hot write strobe
// CSR_RD_EN       out  NUM_SLV          one-hot read strobe
// CSR_RD_DATA     in   NUM_SLV*DATA_W   slave read data; slave i at [i*DATA_W +: DATA_W]
// CSR_RD_DATA_V   in   NUM_SLV          slave read-data valid
// oRD_TMO_CNT     out  16               saturating count of read timeouts
// oRD_DROP_CNT    out  16               saturating count of reads dropped while busy
// BEHAVIOUR
// - Reset: all outputs 0; FSM IDLE; counters 0.
// - Stage 1: iMM_* registered into laddr/lwen/lren/lwdata. CSR_ADDR, CSR_WR_DATA, CSR_WR_EN
//   and CSR_RD_EN are driven from stage 1. CSR strobes are seen 1 cycle after the master strobe.
// - sel = laddr[ADDR_W-1 -: SEL_W]. CSR_WR_EN[sel] = lwen when sel < NUM_SLV.
// - Writes are posted and forwarded in any FSM state. Unmapped writes are silently discarded.
// - FSM IDLE: lren && mapped  -> CSR_RD_EN[sel]=1, capture sel and laddr, go WAIT.
//   lren && unmapped          -> load {32'h5555_AAAA, zero-pad, laddr} into the output register; stay IDLE.
// - FSM WAIT: only CSR_RD_DATA_V[cap_sel] is honoured; valids from other slaves are ignored.
//   On valid: register that slave's data, go IDLE. Timer counts cycles in WAIT.
//   Timer == RD_TIMEOUT: return {32'hDEAD_BEEF, zero-pad, cap_addr}, increment oRD_TMO_CNT, go IDLE.
//   If valid and timeout occur in the same cycle, valid wins.
// - lren while in WAIT: the read is dropped. No CSR_RD_EN and no completion are issued;
//   oRD_DROP_CNT increments.
// - Output register: oMM_RD_DATA/oMM_RD_DATA_V load 1 cycle after the completion event.
//   Unmapped read latency: iMM_RD_EN @T -> oMM_RD_DATA_V @T+2.
//   Mapped read: slave valid @S -> oMM_RD_DATA_V @S+1. A slave answering in the same cycle as
//   CSR_RD_EN gives T+2.
// - oMM_RD_BUSY = (state==WAIT). It is low on the cycle oMM_RD_DATA_V is asserted.
// - Both counters saturate at 16'hFFFF and never wrap.
// - Reset mid-read clears the FSM with no completion; a slave response arriving after reset is ignored.
// - oMM_RD_DATA holds its value between completions.
// STRUCTURE
// - Package xx_mm_dec_pkg: state enum {IDLE,WAIT}; constants UNMAP_SIG=32'h5555_AAAA and TMO_SIG=32'hDEAD_BEEF.
// - Sub-module xx_mm_rd_tracker: FSM, timer, captured sel/addr, read mux, drop/timeout counters.
//   Top level holds stage-1 registers, decode and the output register.
// TESTING (NUM_SLV=4, SEL_W=4, RD_TIMEOUT=255)
// - Write 0x0412 data 0xA5: CSR_WR_EN=4'b0010 and CSR_ADDR=0x012 one cycle later; no read-side activity.
// - Read 0x3C05, unmapped: oMM_RD_DATA=64'h5555_AAAA_0000_3C05 two cycles later; BUSY stays 0.
// - Read 0x0801, slave 2 returns 0x1234 after 5 cycles: single valid with 0x1234; BUSY high for 5 cycles.
// - Read slave 3 with no response: after 255 WAIT cycles data=64'hDEAD_BEEF_0000_0C00; oRD_TMO_CNT=1.
// - Second read during WAIT, plus a slave-1 valid while waiting on slave 0: oRD_DROP_CNT=1;
//   the stray valid is ignored; exactly one completion carries slave 0 data.
// - Assert rst_n low during WAIT, then a late slave valid: no oMM_RD_DATA_V; BUSY=0; counters 0.

Source files
------------

// File: rtl/xx_mm_dec_pkg.sv
// Shared types and constants for the MMIO multi-slave address decoder.
//   rd_state_e : read tracker state (IDLE, WAIT)
//   UNMAP_SIG  : upper word returned for reads that hit no slave
//   TMO_SIG    : upper word returned when a slave never answers
package xx_mm_dec_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } rd_state_e;

    localparam logic [31:0] UNMAP_SIG = 32'h5555_AAAA;
    localparam logic [31:0] TMO_SIG   = 32'hDEAD_BEEF;

endpackage

// File: rtl/xx_mm_rd_tracker.sv
// Read-side tracker for the MMIO decoder: owns the single outstanding read.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   lren, laddr         stage-1 read strobe and full word address
//   sel, mapped         decoded slave index and whether it hits a slave
//   rd_data, rd_data_v  packed slave read data / valids
//   rd_issue            read is forwarded to slave 'sel' this cycle
//   busy                a read is outstanding (WAIT)
//   cmpl_v, cmpl_data   completion event this cycle (registered by the top)
//   tmo_cnt, drop_cnt   saturating debug counters
module xx_mm_rd_tracker
    import xx_mm_dec_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 64,
    parameter int SEL_W      = 4,
    parameter int NUM_SLV    = 4,
    parameter int RD_TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      lren,
    input  logic                      mapped,
    input  logic [SEL_W-1:0]          sel,
    input  logic [ADDR_W-1:0]         laddr,
    input  logic [NUM_SLV*DATA_W-1:0] rd_data,
    input  logic [NUM_SLV-1:0]        rd_data_v,
    output logic                      rd_issue,
    output logic                      busy,
    output logic                      cmpl_v,
    output logic [DATA_W-1:0]         cmpl_data,
    output logic [15:0]               tmo_cnt,
    output logic [15:0]               drop_cnt
);

    localparam int TMR_W = $clog2(RD_TIMEOUT + 1);

    rd_state_e          state, state_nxt;
    logic [SEL_W-1:0]   cap_sel;
    logic [ADDR_W-1:0]  cap_addr;
    logic [TMR_W-1:0]   tmr;
    logic [SEL_W-1:0]   mux_sel;
    logic               slv_v;
    logic [DATA_W-1:0]  slv_data;
    logic [DATA_W-1:0]  unmap_word, tmo_word;
    logic               tmo_fire, drop;

    assign busy = (state == WAIT);

    // In IDLE the slave being addressed right now may answer in the same
    // cycle as its strobe, so the mux follows the live sel; in WAIT only
    // the captured slave is listened to.
    assign mux_sel = busy ? cap_sel : sel;

    always_comb begin
        slv_v    = 1'b0;
        slv_data = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (mux_sel == SEL_W'(i)) begin
                slv_v    = rd_data_v[i];
                slv_data = rd_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Signature words: tag in the top 32 bits, address in the bottom bits.
    always_comb begin
        unmap_word                    = '0;
        unmap_word[ADDR_W-1:0]        = laddr;
        unmap_word[DATA_W-1 -: 32]    = UNMAP_SIG;
        tmo_word                      = '0;
        tmo_word[ADDR_W-1:0]          = cap_addr;
        tmo_word[DATA_W-1 -: 32]      = TMO_SIG;
    end

    always_comb begin
        state_nxt = state;
        rd_issue  = 1'b0;
        cmpl_v    = 1'b0;
        cmpl_data = '0;
        tmo_fire  = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (lren) begin
                    if (mapped) begin
                        rd_issue = 1'b1;
                        if (slv_v) begin
                            cmpl_v    = 1'b1;
                            cmpl_data = slv_data;
                        end else begin
                            state_nxt = WAIT;
                        end
                    end else begin
                        cmpl_v    = 1'b1;
                        cmpl_data = unmap_word;
                    end
                end
            end
            WAIT: begin
                drop = lren;
                // A valid in the timeout cycle still delivers real data.
                if (slv_v) begin
                    cmpl_v    = 1'b1;
                    cmpl_data = slv_data;
                    state_nxt = IDLE;
                end else if (tmr == TMR_W'(RD_TIMEOUT)) begin
                    cmpl_v    = 1'b1;
                    cmpl_data = tmo_word;
                    tmo_fire  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cap_sel  <= '0;
            cap_addr <= '0;
            tmr      <= '0;
            tmo_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (rd_issue) begin
                cap_sel  <= sel;
                cap_addr <= laddr;
            end
            // Timer holds the 1-based index of the current WAIT cycle.
            if (state == IDLE)
                tmr <= TMR_W'(1);
            else
                tmr <= tmr + TMR_W'(1);
            if (tmo_fire && tmo_cnt != 16'hFFFF)
                tmo_cnt <= tmo_cnt + 16'd1;
            if (drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/xx_mm_multi_addr_decoder.sv
// MMIO address decoder between the PCIe BAR master and NUM_SLV CSR slaves.
// The top SEL_W address bits pick a slave, the rest form the slave offset.
// Writes are posted; one read may be outstanding, with timeout and debug
// counters handled by xx_mm_rd_tracker. DATA_W must exceed 32 + ADDR_W so
// the signature words fit.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   iMM_WR_EN/RD_EN/ADDR/WR_DATA   master request (single-cycle strobes)
//   oMM_RD_DATA/_V, oMM_RD_BUSY    read completion and outstanding flag
//   CSR_ADDR, CSR_WR_DATA          broadcast offset / write data
//   CSR_WR_EN, CSR_RD_EN           one-hot slave strobes
//   CSR_RD_DATA, CSR_RD_DATA_V     packed slave responses
//   oRD_TMO_CNT, oRD_DROP_CNT      saturating debug counters
module xx_mm_multi_addr_decoder
    import xx_mm_dec_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 64,
    parameter int SEL_W      = 4,
    parameter int NUM_SLV    = 4,
    parameter int RD_TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      iMM_WR_EN,
    input  logic                      iMM_RD_EN,
    input  logic [ADDR_W-1:0]         iMM_ADDR,
    input  logic [DATA_W-1:0]         iMM_WR_DATA,
    output logic [DATA_W-1:0]         oMM_RD_DATA,
    output logic                      oMM_RD_DATA_V,
    output logic                      oMM_RD_BUSY,
    output logic [ADDR_W-SEL_W-1:0]   CSR_ADDR,
    output logic [DATA_W-1:0]         CSR_WR_DATA,
    output logic [NUM_SLV-1:0]        CSR_WR_EN,
    output logic [NUM_SLV-1:0]        CSR_RD_EN,
    input  logic [NUM_SLV*DATA_W-1:0] CSR_RD_DATA,
    input  logic [NUM_SLV-1:0]        CSR_RD_DATA_V,
    output logic [15:0]               oRD_TMO_CNT,
    output logic [15:0]               oRD_DROP_CNT
);

    localparam logic [SEL_W:0] NUM_SLV_W = (SEL_W+1)'(NUM_SLV);

    logic [ADDR_W-1:0] laddr;
    logic              lwen, lren;
    logic [DATA_W-1:0] lwdata;
    logic [SEL_W-1:0]  sel;
    logic              mapped;
    logic              rd_issue;
    logic              cmpl_v;
    logic [DATA_W-1:0] cmpl_data;

    // Stage 1: master request register; all CSR outputs come from here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            laddr  <= '0;
            lwen   <= 1'b0;
            lren   <= 1'b0;
            lwdata <= '0;
        end else begin
            laddr  <= iMM_ADDR;
            lwen   <= iMM_WR_EN;
            lren   <= iMM_RD_EN;
            lwdata <= iMM_WR_DATA;
        end
    end

    assign sel         = laddr[ADDR_W-1 -: SEL_W];
    assign mapped      = ({1'b0, sel} < NUM_SLV_W);
    assign CSR_ADDR    = laddr[ADDR_W-SEL_W-1:0];
    assign CSR_WR_DATA = lwdata;

    // Only indices below NUM_SLV have a strobe bit, so an unmapped sel
    // simply matches nothing and the access is discarded.
    always_comb begin
        CSR_WR_EN = '0;
        CSR_RD_EN = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            CSR_WR_EN[i] = lwen     && (sel == SEL_W'(i));
            CSR_RD_EN[i] = rd_issue && (sel == SEL_W'(i));
        end
    end

    xx_mm_rd_tracker #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .SEL_W      (SEL_W),
        .NUM_SLV    (NUM_SLV),
        .RD_TIMEOUT (RD_TIMEOUT)
    ) u_rd_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .lren       (lren),
        .mapped     (mapped),
        .sel        (sel),
        .laddr      (laddr),
        .rd_data    (CSR_RD_DATA),
        .rd_data_v  (CSR_RD_DATA_V),
        .rd_issue   (rd_issue),
        .busy       (oMM_RD_BUSY),
        .cmpl_v     (cmpl_v),
        .cmpl_data  (cmpl_data),
        .tmo_cnt    (oRD_TMO_CNT),
        .drop_cnt   (oRD_DROP_CNT)
    );

    // Output register: data holds between completions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oMM_RD_DATA   <= '0;
            oMM_RD_DATA_V <= 1'b0;
        end else begin
            oMM_RD_DATA_V <= cmpl_v;
            if (cmpl_v)
                oMM_RD_DATA <= cmpl_data;
        end
    end

endmodule

// File: tb/tb_xx_mm_multi_addr_decoder.sv
// Directed bench for xx_mm_multi_addr_decoder with a cycle model of the
// master/slave transaction rules and hand-computed scenario checks.
module tb_xx_mm_multi_addr_decoder;

    localparam int A = 14;
    localparam int D = 64;
    localparam int S = 4;
    localparam int N = 4;
    localparam int TMO = 255;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           iMM_WR_EN, iMM_RD_EN;
    logic [A-1:0]   iMM_ADDR;
    logic [D-1:0]   iMM_WR_DATA;
    logic [D-1:0]   oMM_RD_DATA;
    logic           oMM_RD_DATA_V, oMM_RD_BUSY;
    logic [A-S-1:0] CSR_ADDR;
    logic [D-1:0]   CSR_WR_DATA;
    logic [N-1:0]   CSR_WR_EN, CSR_RD_EN;
    logic [N*D-1:0] CSR_RD_DATA;
    logic [N-1:0]   CSR_RD_DATA_V;
    logic [15:0]    oRD_TMO_CNT, oRD_DROP_CNT;

    xx_mm_multi_addr_decoder #(
        .ADDR_W(A), .DATA_W(D), .SEL_W(S), .NUM_SLV(N), .RD_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .iMM_WR_EN(iMM_WR_EN), .iMM_RD_EN(iMM_RD_EN),
        .iMM_ADDR(iMM_ADDR), .iMM_WR_DATA(iMM_WR_DATA),
        .oMM_RD_DATA(oMM_RD_DATA), .oMM_RD_DATA_V(oMM_RD_DATA_V),
        .oMM_RD_BUSY(oMM_RD_BUSY),
        .CSR_ADDR(CSR_ADDR), .CSR_WR_DATA(CSR_WR_DATA),
        .CSR_WR_EN(CSR_WR_EN), .CSR_RD_EN(CSR_RD_EN),
        .CSR_RD_DATA(CSR_RD_DATA), .CSR_RD_DATA_V(CSR_RD_DATA_V),
        .oRD_TMO_CNT(oRD_TMO_CNT), .oRD_DROP_CNT(oRD_DROP_CNT)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // out_slv = slave index of the outstanding read, -1 when none.
    int           out_slv = -1;
    int           waited  = 0;
    logic [A-1:0] out_addr = '0;
    logic         p_rd = 1'b0, p_wr = 1'b0;
    logic [A-1:0] p_addr = '0;
    logic [D-1:0] p_wdata = '0;
    logic         e_v = 1'b0, e_busy = 1'b0;
    logic [D-1:0] e_data = '0;
    logic [N-1:0] e_wr = '0, e_rd = '0;
    logic [15:0]  m_tmo = '0, m_drop = '0;

    initial forever begin
        int slv;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            out_slv = -1; waited = 0; out_addr = '0;
            p_rd = 0; p_wr = 0; p_addr = '0; p_wdata = '0;
            e_v = 0; e_data = '0; m_tmo = '0; m_drop = '0;
        end else begin
            e_v = 0;
            slv = int'(p_addr[A-1 -: S]);
            if (out_slv >= 0) begin
                waited++;
                if (p_rd && m_drop != 16'hFFFF) m_drop++;
                if (CSR_RD_DATA_V[out_slv]) begin
                    e_v = 1; e_data = CSR_RD_DATA[out_slv*D +: D]; out_slv = -1;
                end else if (waited == TMO) begin
                    e_v = 1; e_data = {32'hDEAD_BEEF, 18'd0, out_addr}; out_slv = -1;
                    if (m_tmo != 16'hFFFF) m_tmo++;
                end
            end else if (p_rd) begin
                if (slv >= N) begin
                    e_v = 1; e_data = {32'h5555_AAAA, 18'd0, p_addr};
                end else if (CSR_RD_DATA_V[slv]) begin
                    e_v = 1; e_data = CSR_RD_DATA[slv*D +: D];
                end else begin
                    out_slv = slv; out_addr = p_addr; waited = 0;
                end
            end
            p_rd = iMM_RD_EN; p_wr = iMM_WR_EN; p_addr = iMM_ADDR; p_wdata = iMM_WR_DATA;
        end
        slv    = int'(p_addr[A-1 -: S]);
        e_busy = (out_slv >= 0);
        e_wr   = (p_wr && slv < N) ? N'(1 << slv) : '0;
        e_rd   = (p_rd && slv < N && out_slv < 0) ? N'(1 << slv) : '0;
    end

    // ---------------- compare + scenario monitor ----------------
    int           mon_v = 0, mon_busy = 0;
    logic [D-1:0] mon_data = '0;

    initial forever begin
        @(negedge clk);
        chk("csr_wr_en", 64'(CSR_WR_EN), 64'(e_wr));
        chk("csr_rd_en", 64'(CSR_RD_EN), 64'(e_rd));
        chk("csr_addr",  64'(CSR_ADDR),  64'(p_addr[A-S-1:0]));
        chk("csr_wdata", CSR_WR_DATA, p_wdata);
        chk("rd_v",      64'(oMM_RD_DATA_V), 64'(e_v));
        chk("rd_data",   oMM_RD_DATA, e_data);
        chk("rd_busy",   64'(oMM_RD_BUSY), 64'(e_busy));
        chk("tmo_cnt",   64'(oRD_TMO_CNT), 64'(m_tmo));
        chk("drop_cnt",  64'(oRD_DROP_CNT), 64'(m_drop));
        if (oMM_RD_DATA_V) begin mon_v++; mon_data = oMM_RD_DATA; end
        if (oMM_RD_BUSY) mon_busy++;
    end

    // ---------------- stimulus ----------------
    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mm_rd(logic [A-1:0] a);
        iMM_RD_EN = 1'b1; iMM_ADDR = a;
        tick();
        iMM_RD_EN = 1'b0;
    endtask

    task automatic mon_clr();
        mon_v = 0; mon_busy = 0; mon_data = '0;
    endtask

    task automatic slv_resp(int s, logic [D-1:0] d);
        CSR_RD_DATA[s*D +: D] = d;
        CSR_RD_DATA_V[s] = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; iMM_WR_EN = 0; iMM_RD_EN = 0; iMM_ADDR = '0;
        iMM_WR_DATA = '0; CSR_RD_DATA = '0; CSR_RD_DATA_V = '0;
        tick(3);
        rst_n = 1'b1;
        tick();
        chk("rst_data", oMM_RD_DATA, 64'h0);
        chk("rst_v_busy", {62'd0, oMM_RD_DATA_V, oMM_RD_BUSY}, 64'h0);
        chk("rst_cnts", {32'd0, oRD_TMO_CNT, oRD_DROP_CNT}, 64'h0);

        // posted write to slave 1, then an unmapped write
        iMM_WR_EN = 1; iMM_ADDR = 14'h0412; iMM_WR_DATA = 64'hA5;
        tick();
        chk("wr_en_s1", 64'(CSR_WR_EN), 64'h2);
        chk("wr_addr",  64'(CSR_ADDR), 64'h012);
        chk("wr_data",  CSR_WR_DATA, 64'hA5);
        chk("wr_no_rd", 64'(CSR_RD_EN), 64'h0);
        iMM_ADDR = 14'h3C00;
        tick();
        chk("wr_unmap", 64'(CSR_WR_EN), 64'h0);
        iMM_WR_EN = 0;
        tick(2);

        // unmapped read
        mon_clr();
        mm_rd(14'h3C05);
        tick(4);
        chk("unmap_cnt",  64'(mon_v), 64'd1);
        chk("unmap_data", mon_data, 64'h5555_AAAA_0000_3C05);
        chk("unmap_busy", 64'(mon_busy), 64'd0);

        // slave 2 answers 5 cycles after its strobe
        mon_clr();
        mm_rd(14'h0801);
        tick(5);
        slv_resp(2, 64'h1234);
        tick();
        CSR_RD_DATA_V = '0;
        tick(3);
        chk("s2_cnt",  64'(mon_v), 64'd1);
        chk("s2_data", mon_data, 64'h1234);
        chk("s2_busy", 64'(mon_busy), 64'd5);

        // slave 1 answers in the strobe cycle
        mon_clr();
        mm_rd(14'h0400);
        slv_resp(1, 64'h77);
        tick();
        CSR_RD_DATA_V = '0;
        tick(3);
        chk("s1_fast_cnt",  64'(mon_v), 64'd1);
        chk("s1_fast_data", mon_data, 64'h77);
        chk("s1_fast_busy", 64'(mon_busy), 64'd0);

        // slave 3 never answers
        mon_clr();
        mm_rd(14'h0C00);
        tick(260);
        chk("tmo_vcnt", 64'(mon_v), 64'd1);
        chk("tmo_data", mon_data, 64'hDEAD_BEEF_0000_0C00);
        chk("tmo_busy", 64'(mon_busy), 64'd255);
        chk("tmo_cnt1", 64'(oRD_TMO_CNT), 64'd1);

        // read slave 0; second read dropped; stray slave-1 valid ignored
        mon_clr();
        mm_rd(14'h0005);
        tick();
        iMM_RD_EN = 1; iMM_ADDR = 14'h0801;
        tick();
        iMM_RD_EN = 0;
        slv_resp(1, 64'hBAD);
        tick();
        CSR_RD_DATA_V = '0;
        iMM_WR_EN = 1; iMM_ADDR = 14'h0C33; iMM_WR_DATA = 64'h5A;
        tick();
        iMM_WR_EN = 0;
        slv_resp(0, 64'hCAFE);
        tick();
        CSR_RD_DATA_V = '0;
        tick(3);
        chk("drop_cnt1",  64'(oRD_DROP_CNT), 64'd1);
        chk("drop_vcnt",  64'(mon_v), 64'd1);
        chk("drop_data",  mon_data, 64'hCAFE);

        // reset while waiting, then a late response
        mm_rd(14'h0C10);
        tick(3);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        mon_clr();
        slv_resp(3, 64'hF00D);
        tick();
        CSR_RD_DATA_V = '0;
        tick(3);
        chk("rst_late_v",    64'(mon_v), 64'd0);
        chk("rst_late_busy", 64'(oMM_RD_BUSY), 64'd0);
        chk("rst_late_cnts", {32'd0, oRD_TMO_CNT, oRD_DROP_CNT}, 64'h0);
        chk("rst_late_data", oMM_RD_DATA, 64'h0);

        tick(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
